// File: rtl/countdown_timer.sv
// Loadable down-counter with selectable decrement (1/STEP2/STEP3), saturating
// terminal detection, a one-cycle Done pulse and optional periodic auto-reload.
module countdown_timer #(
  parameter int WIDTH = 16,
  parameter int STEP2 = 2,
  parameter int STEP3 = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Par,
  input  logic             ParLd,
  input  logic             Init,
  input  logic [1:0]       Count,
  input  logic             Start,
  input  logic             Periodic,
  output logic [WIDTH-1:0] Res,
  output logic             Bo,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  logic [WIDTH-1:0] w_step;
  logic             w_terminal;
  logic             w_res_zero;

  // Step constants are truncated to the counter width.
  always_comb begin
    w_step = '0;
    case (Count)
      2'd1:    w_step = WIDTH'(1);
      2'd2:    w_step = WIDTH'(STEP2);
      2'd3:    w_step = WIDTH'(STEP3);
      default: w_step = '0;
    endcase
  end

  assign w_res_zero = (r_res == '0);
  // Saturating: any step that reaches or crosses zero is the terminal event.
  assign w_terminal = (Count != 2'd0) && (r_res <= w_step);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_res    <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (Init) begin
        r_state  <= IDLE;
        r_res    <= '0;
        r_reload <= '0;
      end else if (ParLd) begin
        r_res    <= Par;
        r_reload <= Par;
      end else begin
        case (r_state)
          IDLE: begin
            if (Start && !w_res_zero)
              r_state <= RUN;
          end
          RUN: begin
            if (w_terminal) begin
              r_done <= 1'b1;
              if (Periodic && (r_reload != '0)) begin
                r_res <= r_reload;
              end else begin
                r_res   <= '0;
                r_state <= IDLE;
              end
            end else if (Count != 2'd0) begin
              r_res <= r_res - w_step;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign Res  = r_res;
  assign Bo   = w_res_zero;
  assign Busy = (r_state == RUN);
  assign Done = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a behavioural
// model built from the timer's load/start/step/terminal rules.
module tb_countdown_timer;
  localparam int W  = 16;
  localparam int S2 = 2;
  localparam int S3 = 5;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [W-1:0] Par;
  logic         ParLd, Init, Start, Periodic;
  logic [1:0]   Count;
  logic [W-1:0] Res;
  logic         Bo, Busy, Done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  longint m_res, m_reload;
  bit     m_run, m_done;

  countdown_timer #(.WIDTH(W), .STEP2(S2), .STEP3(S3)) dut (
    .Clk(Clk), .Rst(Rst), .Par(Par), .ParLd(ParLd), .Init(Init),
    .Count(Count), .Start(Start), .Periodic(Periodic),
    .Res(Res), .Bo(Bo), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Res"},  {48'd0, Res}, 64'(m_res));
    check({tag, ".Bo"},   {63'd0, Bo},   64'(m_res == 0));
    check({tag, ".Busy"}, {63'd0, Busy}, 64'(m_run));
    check({tag, ".Done"}, {63'd0, Done}, 64'(m_done));
  endtask

  function automatic longint step_of(input logic [1:0] c);
    longint modulus;
    modulus = 64'sd1 << W;
    case (c)
      2'd1:    return 1;
      2'd2:    return S2 % modulus;
      2'd3:    return S3 % modulus;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input longint p, input bit ld, input bit ini,
                            input logic [1:0] c, input bit st, input bit per);
    longint s;
    m_done = 0;
    s = step_of(c);
    if (ini) begin
      m_res = 0; m_reload = 0; m_run = 0;
    end else if (ld) begin
      m_res = p; m_reload = p;
    end else if (!m_run) begin
      if (st && m_res != 0) m_run = 1;
    end else if (c != 0) begin
      if (m_res > s) m_res = m_res - s;
      else begin
        m_done = 1;
        if (per && m_reload != 0) m_res = m_reload;
        else begin
          m_res = 0; m_run = 0;
        end
      end
    end
  endtask

  task automatic cyc(input string tag, input logic [W-1:0] p, input bit ld,
                     input bit ini, input logic [1:0] c, input bit st, input bit per);
    Par = p; ParLd = ld; Init = ini; Count = c; Start = st; Periodic = per;
    @(posedge Clk);
    model_step(longint'(p), ld, ini, c, st, per);
    #1;
    if (Done === 1'b1) done_cnt++;
    check_all(tag);
  endtask

  task automatic model_reset();
    m_res = 0; m_reload = 0; m_run = 0; m_done = 0;
  endtask

  initial begin
    logic [W-1:0] rp;
    int d;
    Rst = 1'b1; Par = '0; ParLd = 0; Init = 0; Count = 2'd0; Start = 0; Periodic = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk); Rst = 1'b0;

    // Async reset in the middle of a run: immediate clear, no Done.
    cyc("rstrun_ld", 16'd100, 1, 0, 2'd0, 0, 0);
    cyc("rstrun_st", 16'd0,   0, 0, 2'd0, 1, 0);
    cyc("rstrun_c1", 16'd0,   0, 0, 2'd1, 0, 0);
    cyc("rstrun_c2", 16'd0,   0, 0, 2'd1, 0, 0);
    #2; Rst = 1'b1; #1;
    model_reset();
    check_all("rst_async");
    @(negedge Clk); Rst = 1'b0;

    // One-shot 3,2,1,0 with single Done.
    done_cnt = 0;
    cyc("os_ld", 16'd3, 1, 0, 2'd0, 0, 0);
    cyc("os_st", 16'd0, 0, 0, 2'd1, 1, 0);
    for (int i = 0; i < 3; i++) cyc("os_c", 16'd0, 0, 0, 2'd1, 0, 0);
    check("os_res0", {48'd0, Res}, 64'd0);
    check("os_busy0", {63'd0, Busy}, 64'd0);
    cyc("os_after", 16'd0, 0, 0, 2'd1, 0, 0);
    check("os_done_cnt", 64'(done_cnt), 64'd1);

    // Step of 5 from 7: 7,2,0 saturating.
    done_cnt = 0;
    cyc("s5_ld", 16'd7, 1, 0, 2'd0, 0, 0);
    cyc("s5_st", 16'd0, 0, 0, 2'd0, 1, 0);
    cyc("s5_a",  16'd0, 0, 0, 2'd3, 0, 0);
    check("s5_res2", {48'd0, Res}, 64'd2);
    cyc("s5_b",  16'd0, 0, 0, 2'd3, 0, 0);
    check("s5_res0", {48'd0, Res}, 64'd0);
    cyc("s5_c",  16'd0, 0, 0, 2'd3, 0, 0);
    check("s5_done_cnt", 64'(done_cnt), 64'd1);

    // Periodic reload of 2: Done every second cycle, Busy stays high.
    cyc("per_ld", 16'd2, 1, 0, 2'd0, 0, 1);
    cyc("per_st", 16'd0, 0, 0, 2'd0, 1, 1);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) cyc("per_c", 16'd0, 0, 0, 2'd1, 0, 1);
    check("per_done_cnt", 64'(done_cnt), 64'd4);
    check("per_busy", {63'd0, Busy}, 64'd1);

    // Load on a terminal edge wins; Init then clears the run.
    cyc("ldt_ld", 16'd1, 1, 0, 2'd0, 0, 0);
    cyc("ldt_st", 16'd0, 0, 0, 2'd0, 1, 0);
    cyc("ldt_hit", 16'd9, 1, 0, 2'd1, 0, 0);
    check("ldt_res9", {48'd0, Res}, 64'd9);
    cyc("ldt_dec", 16'd0, 0, 0, 2'd2, 0, 0);
    cyc("init_run", 16'd0, 0, 1, 2'd1, 1, 1);
    check("init_busy0", {63'd0, Busy}, 64'd0);

    // IDLE: Start with zero ignored, Count ignored with nonzero Res.
    cyc("idle_st0", 16'd0, 0, 0, 2'd3, 1, 0);
    cyc("idle_ld",  16'hFFFF, 1, 0, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("idle_cnt", 16'd0, 0, 0, 2'(i + 1), 0, 0);
    check("idle_hold", {48'd0, Res}, 64'hFFFF);
    cyc("max_st", 16'd0, 0, 0, 2'd0, 1, 0);
    cyc("max_dec", 16'd0, 0, 0, 2'd3, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      d = $urandom_range(0, 99);
      rp = (d < 10) ? W'($urandom) : W'($urandom_range(0, 12));
      cyc("rand", rp, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
